ddr2_arbiter: RTL and testbench
===============================

DDR2_ARBITER -- requirements
Module: ddr2_arbiter

Interface
REQ-001 Parameter FRAME_WORDS, default 307200, 32-bit words per frame (640x480).
REQ-002 Parameter BANK1_BASE, default 32'h0020_0000, byte base address of frame bank 1; bank 0 base is 0.
REQ-003 Parameter BURST_MAX, default 16, max consecutive grants to one requester while the other is requesting.
REQ-004 Reset is reset_n, synchronous, active-low; clock is ctrl_clk.
REQ-005 ctrl_clk  in  1  controller clock; all logic on rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 wr_req  in  1  write requester holds a word (camera FIFO not empty).
REQ-008 wr_data  in  32  word to write; valid while wr_req high.
REQ-009 wr_ack  out  1  one-cycle pulse: wr_data captured, requester pops.
REQ-010 rd_req  in  1  read requester has space for one word.
REQ-011 rd_data  out  32  read word, valid with rd_valid.
REQ-012 rd_valid  out  1  one-cycle pulse: rd_data valid.
REQ-013 mem_addr  out  32  byte address to memory port.
REQ-014 mem_write / mem_read  out  1 each  memory command strobes.
REQ-015 mem_wdata  out  32  memory write data.
REQ-016 mem_rdata  in  32  memory read data, valid when mem_read high and mem_waitrequest low.
REQ-017 mem_waitrequest  in  1  memory stall; command completes on a cycle with strobe high and mem_waitrequest low.
REQ-018 frame_done  out  1  one-cycle pulse when the last word of a frame is written.
REQ-019 wr_bank / rd_bank  out  1 each  bank currently written / read.

Function
REQ-020 FSM states IDLE, WR_ACC, RD_ACC; at most one of mem_write/mem_read high in any cycle.
REQ-021 IDLE: wr_req only -> WR_ACC; rd_req only and frame_valid -> RD_ACC; both eligible -> side not equal to last_grant; none -> IDLE.
REQ-022 Grant cycle (edge entering WR_ACC): wr_ack pulses, mem_wdata <= wr_data, mem_addr <= wr_base + 4*wr_idx, mem_write <= 1.
REQ-023 Entering RD_ACC: mem_addr <= rd_base + 4*rd_idx, mem_read <= 1.
REQ-024 mem_addr, mem_wdata and strobe held constant while mem_waitrequest high; no timeout.
REQ-025 Read completion: rd_data <= mem_rdata and rd_valid pulses on the following cycle (latency 1 after completion).
REQ-026 On completion: same side requesting and (other side idle or burst_cnt < BURST_MAX-1) -> re-grant same side back-to-back, burst_cnt+1; else other side eligible -> switch, burst_cnt <= 0; else IDLE.
REQ-027 wr_idx, rd_idx are word counters 0..FRAME_WORDS-1, incremented at their own completion, wrapping to 0.
REQ-028 Write wrap: frame_done pulses, done_bank <= wr_bank, wr_bank toggles, frame_valid <= 1.
REQ-029 Read wrap: rd_bank <= done_bank; rd_bank changes at no other time (no tearing).
REQ-030 Reads not granted while frame_valid is 0; rd_req is ignored, not queued.
REQ-031 Write wrap and read wrap on the same edge: rd_bank takes the pre-update done_bank.
REQ-032 Requests deasserting during an access do not abort it.

Reset
REQ-033 On reset: state IDLE, all strobes/pulses 0, mem_addr/mem_wdata/rd_data 0, wr_idx=rd_idx=0, wr_bank=0, rd_bank=0, done_bank=0, frame_valid=0, burst_cnt=0, last_grant=read.
REQ-034 Reset mid-access drops mem_write/mem_read at that edge; no completion, ack, or pulse is generated.

Structure
REQ-035 Shared package holds FSM state encoding, grant-side enum, and default FRAME_WORDS/BANK1_BASE constants.
REQ-036 One sub-module natural: ddr2_frame_addr_gen (index counters, bank toggle, base add); arbitration FSM stays in top.

Verification (FRAME_WORDS=4, BURST_MAX=2)
REQ-037 Four writes, waitrequest 0 -> mem_addr 0,4,8,12; wr_ack x4; frame_done on 4th; wr_bank=1.
REQ-038 rd_req high before any frame -> no mem_read; after frame done -> reads at bank 0 addresses 0,4,8,12.
REQ-039 wr_req and rd_req held continuously -> grant sequence W,W,R,R,W,W.
REQ-040 mem_waitrequest high 3 cycles on a write -> addr/data/strobe stable 4 cycles, single wr_ack, single index step.
REQ-041 Reader mid-frame 1 in bank 0 while writer wraps bank 1 -> rd_bank stays 0 until rd_idx wraps, then 1.
REQ-042 reset_n low during stalled read -> next cycle mem_read=0, rd_valid=0, all counters 0.

Source files
------------

// File: rtl/ddr2_arbiter_pkg.sv
// Shared types and defaults for the DDR2 frame-buffer arbiter.
package ddr2_arbiter_pkg;

  // Arbitration FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_ACC = 2'd1,
    ST_RD_ACC = 2'd2
  } arb_state_t;

  // Which requester received the most recent grant.
  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_side_t;

  // 640x480 frame of 32-bit words; bank 1 sits 2 MiB above bank 0.
  localparam int          DEF_FRAME_WORDS = 307200;
  localparam logic [31:0] DEF_BANK1_BASE  = 32'h0020_0000;
  localparam int          DEF_BURST_MAX   = 16;

  // Byte address of word 'idx' inside a bank starting at 'base'.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/ddr2_frame_addr_gen.sv
// Frame word counters, double-buffer bank bookkeeping and address formation.
// Presents both the current address and the address that follows a
// completion, so the arbiter can issue back-to-back accesses without a bubble.
module ddr2_frame_addr_gen
  import ddr2_arbiter_pkg::*;
#(
  parameter int          FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [31:0] BANK1_BASE  = DEF_BANK1_BASE
) (
  input  logic        ctrl_clk,
  input  logic        reset_n,
  input  logic        i_wr_done,
  input  logic        i_rd_done,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_addr_next,
  output logic [31:0] o_rd_addr,
  output logic [31:0] o_rd_addr_next,
  output logic        o_wr_bank,
  output logic        o_rd_bank,
  output logic        o_frame_done,
  output logic        o_frame_valid
);

  localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_done_bank;
  logic             r_frame_valid;
  logic             r_frame_done;

  logic             w_wr_last;
  logic             w_rd_last;
  logic [IDX_W-1:0] w_wr_idx_inc;
  logic [IDX_W-1:0] w_rd_idx_inc;
  logic             w_wr_bank_after;
  logic             w_rd_bank_after;

  function automatic logic [31:0] bank_base(input logic bank);
    return bank ? BANK1_BASE : 32'h0000_0000;
  endfunction

  assign w_wr_last    = (r_wr_idx == LAST_IDX);
  assign w_rd_last    = (r_rd_idx == LAST_IDX);
  assign w_wr_idx_inc = w_wr_last ? '0 : r_wr_idx + 1'b1;
  assign w_rd_idx_inc = w_rd_last ? '0 : r_rd_idx + 1'b1;

  // Bank in use after the pending completion: the writer flips to the other
  // buffer, the reader moves to the most recently finished frame.
  assign w_wr_bank_after = w_wr_last ? ~r_wr_bank : r_wr_bank;
  assign w_rd_bank_after = w_rd_last ? r_done_bank : r_rd_bank;

  assign o_wr_addr      = word_addr(bank_base(r_wr_bank), 32'(r_wr_idx));
  assign o_wr_addr_next = word_addr(bank_base(w_wr_bank_after), 32'(w_wr_idx_inc));
  assign o_rd_addr      = word_addr(bank_base(r_rd_bank), 32'(r_rd_idx));
  assign o_rd_addr_next = word_addr(bank_base(w_rd_bank_after), 32'(w_rd_idx_inc));

  assign o_wr_bank     = r_wr_bank;
  assign o_rd_bank     = r_rd_bank;
  assign o_frame_done  = r_frame_done;
  assign o_frame_valid = r_frame_valid;

  // Advance word indices on completion; swap banks only at frame boundaries.
  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_done_bank   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_wr_done) begin
        r_wr_idx <= w_wr_idx_inc;
        if (w_wr_last) begin
          r_frame_done  <= 1'b1;
          r_done_bank   <= r_wr_bank;
          r_wr_bank     <= ~r_wr_bank;
          r_frame_valid <= 1'b1;
        end
      end
      // The reader reads the old done_bank even if the writer wraps on
      // this same edge, so a half-updated buffer is never selected.
      if (i_rd_done) begin
        r_rd_idx <= w_rd_idx_inc;
        if (w_rd_last) begin
          r_rd_bank <= r_done_bank;
        end
      end
    end
  end

endmodule

// File: rtl/ddr2_arbiter.sv
// Two-port arbiter sharing one DDR2 memory port between a camera writer and
// a display reader, with double-buffered frames and bounded burst fairness.
module ddr2_arbiter
  import ddr2_arbiter_pkg::*;
#(
  parameter int          FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [31:0] BANK1_BASE  = DEF_BANK1_BASE,
  parameter int          BURST_MAX   = DEF_BURST_MAX
) (
  input  logic        ctrl_clk,
  input  logic        reset_n,
  input  logic        i_wr_req,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_write,
  output logic        o_mem_read,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_waitrequest,
  output logic        o_frame_done,
  output logic        o_wr_bank,
  output logic        o_rd_bank
);

  localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  arb_state_t         r_state;
  grant_side_t        r_last_grant;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_wr_ack;
  logic               r_rd_valid;
  logic [31:0]        r_rd_data;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_write;
  logic               r_mem_read;

  logic        w_wr_elig;
  logic        w_rd_elig;
  logic        w_wr_done;
  logic        w_rd_done;
  logic        w_go_wr;
  logic        w_go_rd;
  logic        w_burst_inc;
  logic        w_frame_valid;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_addr_next;
  logic [31:0] w_rd_addr;
  logic [31:0] w_rd_addr_next;

  assign w_wr_elig = i_wr_req;
  assign w_rd_elig = i_rd_req & w_frame_valid;
  assign w_wr_done = (r_state == ST_WR_ACC) & r_mem_write & ~i_mem_waitrequest;
  assign w_rd_done = (r_state == ST_RD_ACC) & r_mem_read & ~i_mem_waitrequest;

  ddr2_frame_addr_gen #(
    .FRAME_WORDS (FRAME_WORDS),
    .BANK1_BASE  (BANK1_BASE)
  ) u_addr_gen (
    .ctrl_clk       (ctrl_clk),
    .reset_n        (reset_n),
    .i_wr_done      (w_wr_done),
    .i_rd_done      (w_rd_done),
    .o_wr_addr      (w_wr_addr),
    .o_wr_addr_next (w_wr_addr_next),
    .o_rd_addr      (w_rd_addr),
    .o_rd_addr_next (w_rd_addr_next),
    .o_wr_bank      (o_wr_bank),
    .o_rd_bank      (o_rd_bank),
    .o_frame_done   (o_frame_done),
    .o_frame_valid  (w_frame_valid)
  );

  // Grant decision: from IDLE alternate on contention; after a completion
  // keep the same side unless the other is waiting and the burst is used up.
  always_comb begin
    w_go_wr     = 1'b0;
    w_go_rd     = 1'b0;
    w_burst_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_elig && w_rd_elig) begin
          if (r_last_grant == GNT_RD) w_go_wr = 1'b1;
          else                        w_go_rd = 1'b1;
        end else if (w_wr_elig) begin
          w_go_wr = 1'b1;
        end else if (w_rd_elig) begin
          w_go_rd = 1'b1;
        end
      end
      ST_WR_ACC: begin
        if (w_wr_done) begin
          if (w_wr_elig && (!w_rd_elig || (r_burst_cnt < BURST_LAST))) begin
            w_go_wr     = 1'b1;
            w_burst_inc = 1'b1;
          end else if (w_rd_elig) begin
            w_go_rd = 1'b1;
          end
        end
      end
      ST_RD_ACC: begin
        if (w_rd_done) begin
          if (w_rd_elig && (!w_wr_elig || (r_burst_cnt < BURST_LAST))) begin
            w_go_rd     = 1'b1;
            w_burst_inc = 1'b1;
          end else if (w_wr_elig) begin
            w_go_wr = 1'b1;
          end
        end
      end
      default: begin
        w_go_wr = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with registered memory command, ack and read-return.
  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_RD;
      r_burst_cnt  <= '0;
      r_wr_ack     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else begin
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      if (w_go_wr) begin
        r_state      <= ST_WR_ACC;
        r_last_grant <= GNT_WR;
        r_wr_ack     <= 1'b1;
        r_mem_wdata  <= i_wr_data;
        r_mem_addr   <= w_wr_done ? w_wr_addr_next : w_wr_addr;
        r_mem_write  <= 1'b1;
        r_mem_read   <= 1'b0;
      end else if (w_go_rd) begin
        r_state      <= ST_RD_ACC;
        r_last_grant <= GNT_RD;
        r_mem_addr   <= w_rd_done ? w_rd_addr_next : w_rd_addr;
        r_mem_write  <= 1'b0;
        r_mem_read   <= 1'b1;
      end else if (w_wr_done || w_rd_done) begin
        r_state     <= ST_IDLE;
        r_mem_write <= 1'b0;
        r_mem_read  <= 1'b0;
      end
      // Saturate so an uncontested long burst cannot wrap the counter and
      // hand the busy side extra grants once the other side shows up.
      if (w_go_wr || w_go_rd) begin
        if (!w_burst_inc)                   r_burst_cnt <= '0;
        else if (r_burst_cnt != BURST_LAST) r_burst_cnt <= r_burst_cnt + 1'b1;
      end else if (w_wr_done || w_rd_done) begin
        r_burst_cnt <= '0;
      end
      if (w_rd_done) begin
        r_rd_data  <= i_mem_rdata;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign o_wr_ack    = r_wr_ack;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_write = r_mem_write;
  assign o_mem_read  = r_mem_read;

endmodule

// File: tb/tb_ddr2_arbiter.sv
// Directed bench for ddr2_arbiter with a 4-word frame and burst limit 2.
module tb_ddr2_arbiter;

  logic        ctrl_clk = 1'b0;
  logic        reset_n;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;
  logic        frame_done;
  logic        wr_bank;
  logic        rd_bank;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] B1 = 32'h0020_0000;

  // Memory stub: read data is a fixed scramble of the requested address.
  function automatic logic [31:0] rdf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = rdf(mem_addr);

  always #5 ctrl_clk = ~ctrl_clk;

  ddr2_arbiter #(
    .FRAME_WORDS (4),
    .BANK1_BASE  (B1),
    .BURST_MAX   (2)
  ) dut (
    .ctrl_clk          (ctrl_clk),
    .reset_n           (reset_n),
    .i_wr_req          (wr_req),
    .i_wr_data         (wr_data),
    .o_wr_ack          (wr_ack),
    .i_rd_req          (rd_req),
    .o_rd_data         (rd_data),
    .o_rd_valid        (rd_valid),
    .o_mem_addr        (mem_addr),
    .o_mem_write       (mem_write),
    .o_mem_read        (mem_read),
    .o_mem_wdata       (mem_wdata),
    .i_mem_rdata       (mem_rdata),
    .i_mem_waitrequest (mem_waitrequest),
    .o_frame_done      (frame_done),
    .o_wr_bank         (wr_bank),
    .o_rd_bank         (rd_bank)
  );

  // Expected grant trace with both requesters held: W,W,R,R,W,W,R,R,W,W.
  logic        g_wr   [0:9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] g_addr [0:9] = '{B1 + 32'h0, B1 + 32'h4, 32'h0, 32'h4, B1 + 32'h8,
                                B1 + 32'hC, 32'h8, 32'hC, 32'h0, 32'h4};
  logic        g_rv   [0:9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] g_rva  [0:9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h8, 32'hC, 32'h0};
  logic        g_fd   [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        g_wb   [0:9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        g_rb   [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("[%0t] %s observed=%h expected=%h ok", $time, tag, obs, exp);
    end else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_req = 1'b0;
    wr_data = '0;
    rd_req = 1'b0;
    mem_waitrequest = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    reset_n = 1'b1;

    // No frame yet: read requests are ignored.
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noframe_mem_read", 32'(mem_read), 32'd0);
    end
    rd_req = 1'b0;

    // First frame: four back-to-back writes into bank 0.
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'h1000 + 32'(i);
      tick();
      chk("wr_addr", mem_addr, 32'(4 * i));
      chk("wr_strobe", 32'(mem_write), 32'd1);
      chk("wr_ack", 32'(wr_ack), 32'd1);
      chk("wr_wdata", mem_wdata, 32'h1000 + 32'(i));
      chk("wr_frame_done_early", 32'(frame_done), 32'd0);
    end
    wr_req = 1'b0;
    tick();
    chk("frame0_done", 32'(frame_done), 32'd1);
    chk("frame0_wr_bank", 32'(wr_bank), 32'd1);
    chk("frame0_mem_write", 32'(mem_write), 32'd0);
    chk("frame0_wr_ack", 32'(wr_ack), 32'd0);
    tick();
    chk("frame0_done_pulse", 32'(frame_done), 32'd0);

    // Read back the finished frame from bank 0.
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_strobe", 32'(mem_read), 32'd1);
      chk("rd_addr", mem_addr, 32'(4 * i));
      chk("rd_valid", 32'(rd_valid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("rd_data", rd_data, rdf(32'(4 * (i - 1))));
    end
    rd_req = 1'b0;
    tick();
    chk("rd_last_valid", 32'(rd_valid), 32'd1);
    chk("rd_last_data", rd_data, rdf(32'hC));
    chk("rd_idle_strobe", 32'(mem_read), 32'd0);
    chk("rd_bank_after_wrap", 32'(rd_bank), 32'd0);

    // Both sides busy: burst-limited alternation and bank hand-over.
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_data = 32'h2000 + 32'(k);
      tick();
      chk($sformatf("grant%0d_write", k), 32'(mem_write), 32'(g_wr[k]));
      chk($sformatf("grant%0d_read", k), 32'(mem_read), 32'(!g_wr[k]));
      chk($sformatf("grant%0d_addr", k), mem_addr, g_addr[k]);
      chk($sformatf("grant%0d_ack", k), 32'(wr_ack), 32'(g_wr[k]));
      if (g_wr[k]) chk($sformatf("grant%0d_wdata", k), mem_wdata, 32'h2000 + 32'(k));
      chk($sformatf("grant%0d_rd_valid", k), 32'(rd_valid), 32'(g_rv[k]));
      if (g_rv[k]) chk($sformatf("grant%0d_rd_data", k), rd_data, rdf(g_rva[k]));
      chk($sformatf("grant%0d_frame_done", k), 32'(frame_done), 32'(g_fd[k]));
      chk($sformatf("grant%0d_wr_bank", k), 32'(wr_bank), 32'(g_wb[k]));
      chk($sformatf("grant%0d_rd_bank", k), 32'(rd_bank), 32'(g_rb[k]));
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    chk("grant_end_write", 32'(mem_write), 32'd0);
    chk("grant_end_read", 32'(mem_read), 32'd0);

    // Stalled write: command held four cycles, single ack, single index step.
    wr_req = 1'b1;
    wr_data = 32'hCAFE_0001;
    mem_waitrequest = 1'b1;
    tick();
    chk("stall_grant_addr", mem_addr, 32'h8);
    chk("stall_grant_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    wr_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("stall_addr", mem_addr, 32'h8);
      chk("stall_wdata", mem_wdata, 32'hCAFE_0001);
      chk("stall_strobe", 32'(mem_write), 32'd1);
      if (i > 0) chk("stall_ack", 32'(wr_ack), 32'd0);
    end
    mem_waitrequest = 1'b0;
    tick();
    chk("stall_done_strobe", 32'(mem_write), 32'd0);
    chk("stall_done_ack", 32'(wr_ack), 32'd0);
    wr_req = 1'b1;
    wr_data = 32'h3003;
    tick();
    chk("stall_next_addr", mem_addr, 32'hC);
    chk("stall_next_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    tick();
    chk("stall_frame_done", 32'(frame_done), 32'd1);
    chk("stall_wr_bank", 32'(wr_bank), 32'd1);

    // Reset while a read is stalled.
    rd_req = 1'b1;
    mem_waitrequest = 1'b1;
    tick();
    chk("rstrd_grant_read", 32'(mem_read), 32'd1);
    chk("rstrd_grant_addr", mem_addr, B1);
    rd_req = 1'b0;
    tick();
    chk("rstrd_hold_read", 32'(mem_read), 32'd1);
    chk("rstrd_hold_valid", 32'(rd_valid), 32'd0);
    reset_n = 1'b0;
    tick();
    chk("rstrd_read", 32'(mem_read), 32'd0);
    chk("rstrd_valid", 32'(rd_valid), 32'd0);
    chk("rstrd_addr", mem_addr, 32'd0);
    chk("rstrd_rd_bank", 32'(rd_bank), 32'd0);
    chk("rstrd_wr_bank", 32'(wr_bank), 32'd0);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    rd_req = 1'b1;
    tick();
    chk("rstrd_post_valid", 32'(rd_valid), 32'd0);
    chk("rstrd_post_noread", 32'(mem_read), 32'd0);
    rd_req = 1'b0;
    wr_req = 1'b1;
    wr_data = 32'h4004;
    tick();
    chk("rstrd_wr_addr", mem_addr, 32'd0);
    chk("rstrd_wr_strobe", 32'(mem_write), 32'd1);
    wr_req = 1'b0;
    tick();
    chk("rstrd_wr_end", 32'(mem_write), 32'd0);
    chk("rstrd_no_frame_done", 32'(frame_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
